// File: rtl/sipo_pkg.sv
// Shared definitions for the pixel window serial-in/parallel-out block.
package sipo_pkg;

  localparam int PIX_W_DEF = 8;
  localparam int DEPTH_DEF = 5;

  typedef logic [PIX_W_DEF-1:0] pixel_t;

  // Width needed to count 0..depth inclusive.
  function automatic int fill_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/window_oreg.sv
// Output pipeline register for the flat window plus fill/valid.
// Updates every cycle so the valid pulse stays one cycle wide.
module window_oreg
  import sipo_pkg::*;
#(
  parameter int WIN_W  = PIX_W_DEF * DEPTH_DEF,
  parameter int FILL_W = fill_w(DEPTH_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIN_W-1:0]  window_d,
  input  logic [FILL_W-1:0] fill_d,
  input  logic              valid_d,
  output logic [WIN_W-1:0]  window_q,
  output logic [FILL_W-1:0] fill_q,
  output logic              valid_q
);

  // Unconditional one-cycle delay of all outputs, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      window_q <= '0;
      fill_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      window_q <= window_d;
      fill_q   <= fill_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: rtl/pixel_window_sipo.sv
// Pixel window SIPO: shifts in one pixel per qualified clock and presents the
// last DEPTH pixels as a flat vector (slot 0 newest). Fill count restarts on
// start-of-line. Optional build macro PIXEL_WINDOW_OREG_EN adds one output
// register stage on all outputs.
module pixel_window_sipo
  import sipo_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_valid,
  input  logic                       i_sol,
  input  logic [PIX_W-1:0]           i_pixel,
  output logic [PIX_W*DEPTH-1:0]     o_window,
  output logic [fill_w(DEPTH)-1:0]   o_fill,
  output logic                       o_valid
);

  localparam int FW = fill_w(DEPTH);
  localparam logic [FW-1:0] FILL_FULL = FW'(DEPTH);

  logic [PIX_W-1:0]       slot [DEPTH];
  logic [FW-1:0]          fill;
  logic [FW-1:0]          fill_nxt;
  logic                   valid_q;
  logic                   valid_nxt;
  logic [PIX_W*DEPTH-1:0] window_flat;

  // Next fill count: restart on line start, saturate at DEPTH while shifting.
  always_comb begin
    fill_nxt = fill;
    if (i_sol) begin
      fill_nxt = i_valid ? FW'(1) : '0;
    end else if (i_valid) begin
      fill_nxt = (fill == FILL_FULL) ? FILL_FULL : fill + FW'(1);
    end
    valid_nxt = i_valid && (fill_nxt == FILL_FULL);
  end

  // Window shift, line-start clear and fill tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) slot[k] <= '0;
      fill    <= '0;
      valid_q <= 1'b0;
    end else begin
      if (i_sol) begin
        for (int k = 1; k < DEPTH; k++) slot[k] <= '0;
        slot[0] <= i_valid ? i_pixel : '0;
      end else if (i_valid) begin
        for (int k = 1; k < DEPTH; k++) slot[k] <= slot[k-1];
        slot[0] <= i_pixel;
      end
      fill    <= fill_nxt;
      valid_q <= valid_nxt;
    end
  end

  // Flatten slots into the output vector.
  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign window_flat[g*PIX_W +: PIX_W] = slot[g];
  end

`ifdef PIXEL_WINDOW_OREG_EN
  window_oreg #(
    .WIN_W  (PIX_W*DEPTH),
    .FILL_W (FW)
  ) u_oreg (
    .clk      (clk),
    .rst_n    (rst_n),
    .window_d (window_flat),
    .fill_d   (fill),
    .valid_d  (valid_q),
    .window_q (o_window),
    .fill_q   (o_fill),
    .valid_q  (o_valid)
  );
`else
  assign o_window = window_flat;
  assign o_fill   = fill;
  assign o_valid  = valid_q;
`endif

endmodule

// File: tb/tb_pixel_window_sipo.sv
// Self-checking bench for pixel_window_sipo: default 8-bit/5-tap instance
// checked against a hand-computed vector table, plus a 10-bit/9-tap instance
// checked against a behavioural shift model.
module tb_pixel_window_sipo;
  import sipo_pkg::*;

`ifdef PIXEL_WINDOW_OREG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  localparam int W2 = 10;
  localparam int D2 = 9;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           valid;
  logic           sol;
  pixel_t         pix1;
  logic [W2-1:0]  pix2;

  logic [39:0]    win1;
  logic [2:0]     fill1;
  logic           ov1;
  logic [W2*D2-1:0] win2;
  logic [3:0]     fill2;
  logic           ov2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pixel_window_sipo dut1 (
    .clk(clk), .rst_n(rst_n), .i_valid(valid), .i_sol(sol), .i_pixel(pix1),
    .o_window(win1), .o_fill(fill1), .o_valid(ov1)
  );

  pixel_window_sipo #(.PIX_W(W2), .DEPTH(D2)) dut2 (
    .clk(clk), .rst_n(rst_n), .i_valid(valid), .i_sol(sol), .i_pixel(pix2),
    .o_window(win2), .o_fill(fill2), .o_valid(ov2)
  );

  // Behavioural model for the 9-tap instance.
  logic [W2-1:0] m_win [D2];
  int            m_fill;
  logic          m_ov;

  typedef struct {
    logic        sol;
    logic        valid;
    pixel_t      pix;
    logic [39:0] win;
    logic [2:0]  fill;
    logic        ov;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < D2; k++) m_win[k] = '0;
    m_fill = 0;
    m_ov   = 1'b0;
  endtask

  task automatic model_step(input logic s, input logic v, input logic [W2-1:0] p);
    if (s) begin
      for (int k = 0; k < D2; k++) m_win[k] = '0;
      m_fill = 0;
    end
    if (v) begin
      for (int k = D2-1; k >= 1; k--) m_win[k] = m_win[k-1];
      m_win[0] = p;
      if (m_fill < D2) m_fill++;
    end
    m_ov = v && (m_fill == D2);
  endtask

  task automatic chk_model(input string tag);
    logic [W2*D2-1:0] exp_win;
    for (int k = 0; k < D2; k++) exp_win[k*W2 +: W2] = m_win[k];
    chk({tag, " win2"},  128'(win2),  128'(exp_win));
    chk({tag, " fill2"}, 128'(fill2), 128'(m_fill));
    chk({tag, " ov2"},   128'(ov2),   128'(m_ov));
  endtask

  // One qualified cycle on both instances; outputs checked after the
  // configured output latency with idle inputs in the extra cycle.
  task automatic apply(input logic s, input logic v, input pixel_t p);
    sol   = s;
    valid = v;
    pix1  = p;
    pix2  = {p[1:0], p};
    @(posedge clk);
    #1;
    model_step(s, v, {p[1:0], p});
    sol   = 1'b0;
    valid = 1'b0;
    if (LAT != 0) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 8'h11, 40'h00_00_00_00_11, 3'd1, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 8'h22, 40'h00_00_00_11_22, 3'd2, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 8'h33, 40'h00_00_11_22_33, 3'd3, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 8'h44, 40'h00_11_22_33_44, 3'd4, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 8'h55, 40'h11_22_33_44_55, 3'd5, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 8'h66, 40'h22_33_44_55_66, 3'd5, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 8'hFF, 40'h22_33_44_55_66, 3'd5, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 8'hFF, 40'h22_33_44_55_66, 3'd5, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 8'hFF, 40'h22_33_44_55_66, 3'd5, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 8'h77, 40'h33_44_55_66_77, 3'd5, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 8'hA0, 40'h00_00_00_00_A0, 3'd1, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 8'hEE, 40'h00_00_00_00_00, 3'd0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 8'h01, 40'h00_00_00_00_01, 3'd1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 8'hCC, 40'h00_00_00_00_01, 3'd1, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 8'h02, 40'h00_00_00_01_02, 3'd2, 1'b0};

    rst_n = 1'b0;
    valid = 1'b0;
    sol   = 1'b0;
    pix1  = '0;
    pix2  = '0;
    model_reset();

    #2;
    chk("reset win1",  128'(win1),  128'(0));
    chk("reset fill1", 128'(fill1), 128'(0));
    chk("reset ov1",   128'(ov1),   128'(0));
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;

    for (int i = 0; i < 15; i++) begin
      apply(tbl[i].sol, tbl[i].valid, tbl[i].pix);
      chk($sformatf("vec%0d win1", i),  128'(win1),  128'(tbl[i].win));
      chk($sformatf("vec%0d fill1", i), 128'(fill1), 128'(tbl[i].fill));
      chk($sformatf("vec%0d ov1", i),   128'(ov1),   128'(tbl[i].ov));
      chk_model($sformatf("vec%0d", i));
    end

    // Fill the 9-tap instance past full; 5-tap saturates along the way.
    apply(1'b1, 1'b1, 8'h80);
    chk_model("deep0");
    for (int i = 1; i < 12; i++) begin
      apply(1'b0, 1'b1, pixel_t'(8'h80 + i));
      chk_model($sformatf("deep%0d", i));
      chk($sformatf("deep%0d fill1", i), 128'(fill1), 128'((i + 1 > 5) ? 5 : i + 1));
      chk($sformatf("deep%0d ov1", i),   128'(ov1),   128'(i + 1 >= 5));
    end
    chk("deep win1", 128'(win1), 128'(40'h87_88_89_8A_8B));

    // Async reset mid-stream with both windows full: outputs clear without a clock edge.
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async win1",  128'(win1),  128'(0));
    chk("async fill1", 128'(fill1), 128'(0));
    chk("async ov1",   128'(ov1),   128'(0));
    chk_model("async");
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;

    // First pixel after reset enters with fill=1 even without line start.
    apply(1'b0, 1'b1, 8'h5A);
    chk("post-reset win1",  128'(win1),  128'(40'h5A));
    chk("post-reset fill1", 128'(fill1), 128'(1));
    chk("post-reset ov1",   128'(ov1),   128'(0));
    chk_model("post-reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got no end expected end");
    $fatal(1);
  end

endmodule
